// File: rtl/typing_pkg.sv
// typing_pkg: shared state encoding, mode values and character codes for the typing game
package typing_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        RUN    = 3'd2,
        CHECK  = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic MODE_STRICT = 1'b0;
    localparam logic MODE_FREE   = 1'b1;

    localparam logic [5:0] CODE_SPACE = 6'd36;
    localparam logic [5:0] CODE_BKSP  = 6'd37;

endpackage

// File: rtl/sec_timer.sv
// sec_timer: clock-tick prescaler feeding a saturating seconds counter
module sec_timer
    import typing_pkg::*;
#(
    parameter int SEC_W         = 10,
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [SEC_W-1:0] sec
);

    localparam int TW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;

    logic [TW-1:0] tick;

    // count enabled cycles; every full second bumps sec until it saturates
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tick <= '0;
            sec  <= '0;
        end else if (en) begin
            if (tick == TW'(TICKS_PER_SEC - 1)) begin
                tick <= '0;
                if (sec != '1) sec <= sec + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

endmodule

// File: rtl/typing_engine.sv
// typing_engine: keystroke checker against a text ROM with strict/free modes, progress pulses and timer
module typing_engine
    import typing_pkg::*;
#(
    parameter int TEXT_LEN      = 299,
    parameter int CHAR_W        = 6,
    parameter int PULSE_EVERY   = 10,
    parameter int ERR_W         = 6,
    parameter int SEC_W         = 10,
    parameter int TICKS_PER_SEC = 100000000,
    localparam int POS_W        = $clog2(TEXT_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              key_valid,
    input  logic [CHAR_W-1:0] key_code,
    input  logic              key_bksp,
    output logic              key_ready,
    output logic [POS_W-1:0]  text_addr,
    input  logic [CHAR_W-1:0] text_char,
    output logic [2:0]        state,
    output logic [POS_W-1:0]  pos,
    output logic [ERR_W-1:0]  wrong_cnt,
    output logic              err_flag,
    output logic              progress_pulse,
    output logic [SEC_W-1:0]  elapsed_sec,
    output logic              done
);

    state_t             st, st_n;
    logic               mode_r, bksp_r, started;
    logic [CHAR_W-1:0]  key_r;
    logic [POS_W-1:0]   hw, new_pos;
    logic               accept, go, match, miss, pulse_hit, timer_en;

    assign state     = st;
    assign key_ready = st == RUN;
    assign done      = st == DONE;
    assign text_addr = pos;
    assign accept    = key_valid & key_ready;
    assign go        = start & (st == IDLE || st == DONE);
    assign timer_en  = (started | accept) & (st == RUN || st == CHECK || st == SETTLE);

    // judge the latched key against the ROM character and derive the new cursor position
    always_comb begin
        match     = key_r == text_char;
        miss      = !bksp_r && !match;
        new_pos   = bksp_r ? ((mode_r == MODE_FREE && pos != '0) ? pos - 1'b1 : pos)
                  : (match || mode_r == MODE_FREE) ? pos + 1'b1 : pos;
        pulse_hit = new_pos > hw
                  && (int'(new_pos) % PULSE_EVERY == 0 || int'(new_pos) == TEXT_LEN);
    end

    // next-state logic
    always_comb begin
        st_n = st;
        case (st)
            IDLE:    st_n = start ? ARM : IDLE;
            ARM:     st_n = RUN;
            RUN:     st_n = accept ? CHECK : RUN;
            CHECK:   st_n = int'(new_pos) == TEXT_LEN ? DONE : SETTLE;
            SETTLE:  st_n = RUN;
            DONE:    st_n = start ? ARM : DONE;
            default: st_n = IDLE;
        endcase
    end

    // state register plus session counters, key latch and progress tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            st             <= IDLE;
            pos            <= '0;
            hw             <= '0;
            wrong_cnt      <= '0;
            err_flag       <= 1'b0;
            progress_pulse <= 1'b0;
            mode_r         <= MODE_STRICT;
            key_r          <= '0;
            bksp_r         <= 1'b0;
            started        <= 1'b0;
        end else begin
            st             <= st_n;
            progress_pulse <= st == CHECK && pulse_hit;
            if (go) begin
                pos       <= '0;
                hw        <= '0;
                wrong_cnt <= '0;
                err_flag  <= 1'b0;
                started   <= 1'b0;
                mode_r    <= mode;
            end
            if (accept) begin
                key_r   <= key_code;
                bksp_r  <= key_bksp;
                started <= 1'b1;
            end
            if (st == CHECK) begin
                pos      <= new_pos;
                hw       <= new_pos > hw ? new_pos : hw;
                err_flag <= miss;
                if (miss && wrong_cnt != '1) wrong_cnt <= wrong_cnt + 1'b1;
            end
        end
    end

    sec_timer #(
        .SEC_W        (SEC_W),
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(go),
        .en (timer_en),
        .sec(elapsed_sec)
    );

endmodule

// File: tb/tb_typing_engine.sv
// tb_typing_engine: randomized scoreboard bench for typing_engine against a session-level model
module tb_typing_engine;

    localparam int TL  = 12;
    localparam int PE  = 5;
    localparam int TPS = 4;
    localparam int EW  = 2;
    localparam int SW  = 2;
    localparam int CW  = 6;
    localparam int PW  = 4;
    localparam int WMAX = (1 << EW) - 1;

    logic          clk = 0, rst = 1, start = 0, mode = 0, key_valid = 0, key_bksp = 0;
    logic [CW-1:0] key_code = '0, text_char;
    logic          key_ready, err_flag, progress_pulse, done;
    logic [PW-1:0] text_addr, pos;
    logic [2:0]    state, prev_st;
    logic [EW-1:0] wrong_cnt;
    logic [SW-1:0] elapsed_sec;

    int tests = 0, fails = 0;
    int rom[TL];

    typedef struct {
        int pos;
        int wrong;
        int err;
        int pulse;
        int done;
    } exp_t;
    exp_t sb[$];

    int m_pos, m_hw, m_wrong, m_free;

    always #5 clk = ~clk;

    typing_engine #(
        .TEXT_LEN(TL), .CHAR_W(CW), .PULSE_EVERY(PE),
        .ERR_W(EW), .SEC_W(SW), .TICKS_PER_SEC(TPS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .key_valid(key_valid), .key_code(key_code), .key_bksp(key_bksp),
        .key_ready(key_ready), .text_addr(text_addr), .text_char(text_char),
        .state(state), .pos(pos), .wrong_cnt(wrong_cnt), .err_flag(err_flag),
        .progress_pulse(progress_pulse), .elapsed_sec(elapsed_sec), .done(done)
    );

    always @(posedge clk)
        text_char <= (int'(text_addr) < TL) ? CW'(rom[int'(text_addr)]) : '0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // result of each judged key appears in SETTLE or the first DONE cycle
    always @(negedge clk) begin
        if (!rst && (state == 3'd4 || (state == 3'd5 && prev_st == 3'd3))) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pos", int'(pos), e.pos);
                chk("wrong_cnt", int'(wrong_cnt), e.wrong);
                chk("err_flag", int'(err_flag), e.err);
                chk("progress_pulse", int'(progress_pulse), e.pulse);
                chk("done", int'(done), e.done);
            end
        end
        prev_st <= state;
    end

    task automatic model_key(input int c, input bit b);
        exp_t e;
        if (b) begin
            if (m_free != 0 && m_pos > 0) m_pos--;
            e.err = 0;
        end else if (c == rom[m_pos]) begin
            m_pos++;
            e.err = 0;
        end else begin
            e.err = 1;
            m_wrong = m_wrong < WMAX ? m_wrong + 1 : WMAX;
            if (m_free != 0) m_pos++;
        end
        e.pulse = (m_pos > m_hw && (m_pos % PE == 0 || m_pos == TL)) ? 1 : 0;
        if (m_pos > m_hw) m_hw = m_pos;
        e.pos   = m_pos;
        e.wrong = m_wrong;
        e.done  = m_pos == TL ? 1 : 0;
        sb.push_back(e);
    endtask

    function automatic int wrong_code();
        return (rom[m_pos] + 1 + int'($urandom_range(0, 50))) % 64;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_pos"}, int'(pos), 0);
        chk({tag, "_wrong"}, int'(wrong_cnt), 0);
        chk({tag, "_err"}, int'(err_flag), 0);
        chk({tag, "_pulse"}, int'(progress_pulse), 0);
        chk({tag, "_sec"}, int'(elapsed_sec), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ready"}, int'(key_ready), 0);
        chk({tag, "_addr"}, int'(text_addr), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
        sb.delete();
    endtask

    task automatic start_session(input bit m);
        start = 1;
        mode  = m;
        @(negedge clk);
        start = 0;
        chk("start_state", int'(state), 1);
        chk("start_pos", int'(pos), 0);
        chk("start_wrong", int'(wrong_cnt), 0);
        chk("start_err", int'(err_flag), 0);
        chk("start_sec", int'(elapsed_sec), 0);
        m_pos = 0; m_hw = 0; m_wrong = 0; m_free = m;
    endtask

    task automatic send_key(input int c, input bit b);
        int n = 0;
        bit r1, r2, r3;
        while (!key_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!key_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        key_valid = 1; key_code = CW'(c); key_bksp = b;
        model_key(c, b);
        @(negedge clk);
        r1 = key_ready;
        key_valid = 1'($urandom_range(0, 1)); key_code = CW'($urandom); key_bksp = 0;
        @(negedge clk);
        r2 = key_ready;
        key_valid = 0;
        if (m_pos != TL) begin
            @(negedge clk);
            r3 = key_ready;
            chk("ready_latency", int'({r1, r2, r3}), 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < TL; i++) rom[i] = i;
        rst = 1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 0;
        @(negedge clk);

        // strict run-through, pulses at 5, 10, 12
        start_session(0);
        for (int i = 0; i < TL; i++) begin
            send_key(i, 0);
            @(negedge clk);
        end
        chk("s1_done", int'(done), 1);

        // strict mismatch then correction; start during RUN ignored
        start_session(0);
        for (int i = 0; i < 3; i++) send_key(i, 0);
        send_key(7, 0);
        send_key(3, 0);
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("run_start_state", int'(state), 2);
        chk("run_start_pos", int'(pos), 4);

        // reset while in CHECK
        key_valid = 1; key_code = 6'd4; key_bksp = 0;
        @(negedge clk);
        key_valid = 0;
        chk("pre_rst_state", int'(state), 3);
        rst = 1;
        @(negedge clk);
        chk_zero("midrst");
        rst = 0;
        @(negedge clk);

        // free mode: backspace does not re-pulse, wrong key advances
        start_session(1);
        for (int i = 0; i < 5; i++) send_key(i, 0);
        send_key(0, 1);
        send_key(0, 1);
        for (int i = 3; i < 6; i++) send_key(i, 0);
        send_key(wrong_code(), 0);
        for (int i = 7; i < TL; i++) send_key(i, 0);

        // free mode backspace at pos 0
        start_session(1);
        send_key(wrong_code(), 0);
        send_key(0, 1);
        send_key(0, 1);
        do_reset();

        // saturation of wrong count and timer; timer idle before first key
        start_session(0);
        repeat (10) @(negedge clk);
        chk("sec_before_key", int'(elapsed_sec), 0);
        send_key(63, 0);
        repeat (4) @(negedge clk);
        chk("sec_one", int'(elapsed_sec), 1);
        repeat (4) send_key(63, 0);
        repeat (20) @(negedge clk);
        chk("sec_sat", int'(elapsed_sec), 3);
        chk("wrong_sat", int'(wrong_cnt), 3);
        do_reset();

        // randomized sessions
        repeat (6) begin
            start_session(1'($urandom_range(0, 1)));
            for (int k = 0; k < 200 && m_pos != TL; k++) begin
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 70) send_key(rom[m_pos], 0);
                else if (r < 85) send_key(wrong_code(), 0);
                else send_key(int'($urandom_range(0, 63)), 1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            if (m_pos != TL) do_reset();
            else begin
                repeat (2) @(negedge clk);
                chk("rnd_done_hold", int'(done), 1);
            end
        end

        repeat (4) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/typing_engine.md
Name: typing_engine

Overview:
- Parametrised typing-game core.
- Replaces the fixed-length, single-mode FSM/CHECK pair with one engine that:
  - reads the article from an external synchronous text ROM,
  - compares accepted keystrokes against the expected character,
  - tracks cursor position, wrong count and elapsed time,
  - emits progress pulses for the IR sender.
- Adds a free-typing mode with backspace, a high-water-mark progress rule and a key_ready handshake.

Parameters:
- TEXT_LEN, 299: article length in characters; 1..2047.
- CHAR_W, 6: character code width.
- PULSE_EVERY, 10: progress pulse period, in characters.
- ERR_W, 6: wrong-counter width; the counter saturates.
- SEC_W, 10: elapsed-seconds width; the counter saturates.
- TICKS_PER_SEC, 100000000: clk cycles per second.
- POS_W, $clog2(TEXT_LEN+1): derived; not overridable.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin or restart a session; honoured in IDLE or DONE only.
- mode  in  1  0 = strict, 1 = free; sampled at start.
- key_valid  in  1  keystroke strobe.
- key_code  in  CHAR_W  keystroke character code.
- key_bksp  in  1  keystroke is backspace; key_code is ignored when set.
- key_ready  out  1  engine can accept a keystroke this cycle.
- text_addr  out  POS_W  ROM address; always equals pos.
- text_char  in  CHAR_W  ROM data; 1-cycle read latency.
- state  out  3  FSM state encoding.
- pos  out  POS_W  cursor position.
- wrong_cnt  out  ERR_W  wrong keystrokes in this session.
- err_flag  out  1  the last compared keystroke was wrong.
- progress_pulse  out  1  one-cycle pulse.
- elapsed_sec  out  SEC_W  seconds since the first accepted key.
- done  out  1  session complete.

Behaviour:
- Reset values: state = IDLE, all other outputs 0, key_ready = 0, high-water mark hw = 0. Reset mid-session aborts to IDLE the following cycle.
- States and transitions:
  - IDLE: start -> ARM. Clears pos, hw, wrong_cnt, err_flag, elapsed_sec and the tick prescaler; latches mode.
  - ARM: one cycle for the ROM fetch -> RUN.
  - RUN: key_ready = 1. A key is accepted when key_valid & key_ready. The key and bksp are latched -> CHECK. key_valid while key_ready = 0 is dropped, not queued.
  - CHECK: evaluates the latched key against text_char; pos, wrong_cnt and err_flag update at the end of this cycle -> SETTLE, or DONE if the new pos == TEXT_LEN.
  - SETTLE: one cycle for the ROM refetch at the new pos -> RUN.
  - DONE: done = 1; counters frozen; start -> ARM with full clear.
- Key-to-next-ready latency: accept at cycle T, CHECK at T+1, SETTLE at T+2, key_ready high again at T+3.
- Strict mode (mode = 0):
  - Match: pos + 1, err_flag = 0.
  - Mismatch: pos held, wrong_cnt + 1, err_flag = 1.
  - Backspace: pos held, err_flag = 0, no count change.
- Free mode (mode = 1):
  - Match: pos + 1, err_flag = 0.
  - Mismatch: pos + 1, wrong_cnt + 1, err_flag = 1.
  - Backspace: pos - 1 if pos > 0, otherwise held; err_flag = 0; wrong_cnt is never decremented.
- wrong_cnt saturates at 2^ERR_W - 1. elapsed_sec saturates at 2^SEC_W - 1.
- progress_pulse:
  - Asserted in the cycle after CHECK (SETTLE or the first DONE cycle).
  - Condition: new pos > hw AND (new pos % PULSE_EVERY == 0 OR new pos == TEXT_LEN).
  - hw updates to max(hw, new pos) at the same time.
  - Re-crossing a position after a backspace never re-pulses.
- Timer:
  - The prescaler starts counting on the first accepted key of the session and runs in RUN, CHECK and SETTLE.
  - elapsed_sec increments when the prescaler reaches TICKS_PER_SEC - 1; the prescaler then wraps to 0.
  - Timer freezes in DONE.
- start asserted in ARM, RUN, CHECK or SETTLE is ignored.
- Simultaneous start and rst: rst wins.
- TEXT_LEN == 1: the first correct key goes straight to DONE with progress_pulse.

Decomposition:
- Shared package typing_pkg holds:
  - state enum IDLE = 0, ARM = 1, RUN = 2, CHECK = 3, SETTLE = 4, DONE = 5,
  - mode constants MODE_STRICT and MODE_FREE,
  - the backspace/space character code constants used across the game.
- One natural sub-module: sec_timer, the prescaler plus saturating seconds counter, with enable and clear inputs.

Test Plan:
All scenarios use TEXT_LEN = 12, PULSE_EVERY = 5, TICKS_PER_SEC = 4, and a ROM holding codes 0..11.
1. Strict, 12 correct keys spaced 4 cycles apart -> pos 0..12; progress_pulse at pos 5, 10, 12; done = 1; wrong_cnt = 0; key_ready re-asserts exactly 3 cycles after each accept.
2. Strict at pos 3, key 7 -> pos stays 3, wrong_cnt = 1, err_flag = 1; then key 3 -> pos 4, err_flag = 0.
3. Free mode:
   - reach pos 5 (pulse fires), backspace twice -> pos 3 with no pulse;
   - retype to 5 -> no pulse; advance to 10 -> pulse;
   - a wrong key at pos 6 -> pos 7, wrong_cnt = 1.
4. Backspace at pos 0 in free mode -> pos 0, err_flag = 0; key_valid pulses while key_ready = 0 -> ignored, pos unchanged.
5. Saturation: ERR_W = 2, 5 wrong strict keys -> wrong_cnt = 3. SEC_W = 2, hold idle in RUN for 20 cycles after the first key -> elapsed_sec = 3.
6. Reset mid-CHECK -> next cycle state = IDLE, all outputs 0. start in DONE -> ARM with counters cleared; start pulsed during RUN -> no effect.
